// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with the HI/LO registers for the MIPS execute stage.
// One operation at a time, DATA_WIDTH+1 cycles each; MTHI/MTLO write HI/LO directly from idle.
`timescale 1ns/1ps
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [5:0]            func,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    orig_a;
  logic [2*W-1:0]  acc;
  logic            sign_p;
  logic            sign_r;
  logic            is_div;
  logic            div_zero;

  logic            is_signed;
  logic            is_mul_func;
  logic            is_div_func;
  logic            accept_md;
  logic [2*W-1:0]  mul_next;
  logic [2*W-1:0]  div_next;
  logic [W:0]      mul_sum;
  logic [W:0]      div_shift;
  logic [W-1:0]    div_diff;
  logic            div_ge;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    fix_hi;
  logic [W-1:0]    fix_lo;

  function automatic logic [W-1:0] abs_w(input logic signed [W-1:0] v);
    return v[W-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic en);
    return en ? (~v + W'(1)) : v;
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v, input logic en);
    return en ? (~v + (2*W)'(1)) : v;
  endfunction

  assign busy        = (state != IDLE);
  assign is_mul_func = (func == F_MULT) || (func == F_MULTU);
  assign is_div_func = (func == F_DIV)  || (func == F_DIVU);
  assign is_signed   = (func == F_MULT) || (func == F_DIV);
  assign accept_md   = (state == IDLE) && start && (is_mul_func || is_div_func);

  always_comb begin
    // Shift-add: low half holds the unconsumed multiplier bits, high half the partial product.
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, a_reg} : {(W+1){1'b0}});
    mul_next  = {mul_sum, acc[W-1:1]};
    // Restoring divide: high half is the remainder, low half shifts dividend out / quotient in.
    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_ge    = (div_shift >= {1'b0, b_reg});
    div_diff  = div_shift[W-1:0] - b_reg;
    div_next  = {(div_ge ? div_diff : div_shift[W-1:0]), acc[W-2:0], div_ge};

    prod_fix  = neg_2w(acc, sign_p);
    fix_hi    = prod_fix[2*W-1:W];
    fix_lo    = prod_fix[W-1:0];
    if (is_div) begin
      if (div_zero) begin
        fix_lo = {W{1'b1}};
        fix_hi = orig_a;
      end else begin
        fix_lo = neg_w(acc[W-1:0], sign_p);
        fix_hi = neg_w(acc[2*W-1:W], sign_r);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept_md) begin
      a_reg    <= is_signed ? abs_w(op_a) : op_a;
      b_reg    <= is_signed ? abs_w(op_b) : op_b;
      orig_a   <= op_a;
      sign_p   <= is_signed && (op_a[W-1] ^ op_b[W-1]);
      sign_r   <= is_signed && op_a[W-1];
      is_div   <= is_div_func;
      div_zero <= (op_b == '0);
      acc      <= {{W{1'b0}}, (is_div_func ? (is_signed ? abs_w(op_a) : op_a)
                                            : (is_signed ? abs_w(op_b) : op_b))};
    end else if (state == MUL) begin
      acc <= mul_next;
    end else if (state == DIV) begin
      acc <= div_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul_func) begin
              state <= MUL;
              cnt   <= '0;
            end else if (is_div_func) begin
              state <= DIV;
              cnt   <= '0;
            end else if (func == F_MTHI) begin
              hi <= op_a;
            end else if (func == F_MTLO) begin
              lo <= op_a;
            end
          end
        end
        MUL, DIV: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) state <= FIX;
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: products, quotients, corner cases, MTHI/MTLO, reset abort.
`timescale 1ns/1ps
module tb_mult_div_unit;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  func = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .func(func),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a rising edge; issues a request and waits (bounded) for done.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
    start = 1'b1; func = f; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; func = '0;
    lat = 1; busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    lat--;
  endtask

  int lat, bc, pulses;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    chk("multu_lat", lat, 33);
    chk("multu_busy_cycles", bc, 33);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    chk("multu_busy_low", {31'b0, busy}, 32'h0);

    run_op(F_MULT, 32'hFFFFFFFD, 32'd5, lat, bc);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFF1);
    chk("mult_done", {31'b0, done}, 32'h1);
    // Back-to-back: issued in the done cycle.
    run_op(F_DIV, 32'hFFFFFFF9, 32'd2, lat, bc);
    chk("div_b2b_lat", lat, 33);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    run_op(F_DIVU, 32'd100, 32'd0, lat, bc);
    chk("divu0_lo", lo, 32'hFFFFFFFF);
    chk("divu0_hi", hi, 32'h00000064);
    run_op(F_DIV, 32'hFFFFFFFB, 32'd0, lat, bc);
    chk("div0_lo", lo, 32'hFFFFFFFF);
    chk("div0_hi", hi, 32'hFFFFFFFB);
    run_op(F_DIVU, 32'd100, 32'd7, lat, bc);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bc);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'h0);

    start = 1'b1; func = F_MTHI; op_a = 32'h1234;
    @(posedge clk); #1;
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_busy", {31'b0, busy}, 32'h0);
    func = F_MTLO; op_a = 32'h5678;
    @(posedge clk); #1;
    start = 1'b0; func = '0;
    chk("mtlo_lo", lo, 32'h5678);
    chk("mtlo_hi", hi, 32'h1234);
    chk("mt_busy", {31'b0, busy}, 32'h0);
    chk("mt_done", {31'b0, done}, 32'h0);

    // MTLO while busy must be dropped; hi/lo hold during the operation.
    start = 1'b1; func = F_MULTU; op_a = 32'd3; op_b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0; func = '0;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; func = F_MTLO; op_a = 32'hDEAD;
    @(posedge clk); #1;
    start = 1'b0; func = '0;
    chk("busy_mtlo_lo", lo, 32'h5678);
    chk("busy_hold_hi", hi, 32'h1234);
    chk("busy_mid", {31'b0, busy}, 32'h1);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("mul34_lo", lo, 32'd12);
    chk("mul34_hi", hi, 32'd0);

    // Reset mid-operation discards the result.
    start = 1'b1; func = F_MULTU; op_a = 32'd7; op_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; func = '0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
    chk("rst_no_done", pulses, 0);
    run_op(F_MULTU, 32'd7, 32'd9, lat, bc);
    chk("fresh_lo", lo, 32'd63);
    chk("fresh_hi", hi, 32'd0);

    // Non-muldiv func is a no-op.
    @(posedge clk); #1;
    start = 1'b1; func = F_ADD; op_a = 32'hAAAA; op_b = 32'h5555;
    @(posedge clk); #1;
    start = 1'b0; func = '0;
    chk("noop_busy", {31'b0, busy}, 32'h0);
    chk("noop_done", {31'b0, done}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("noop_busy_later", {31'b0, busy}, 32'h0);
    chk("noop_lo", lo, 32'd63);
    chk("noop_hi", hi, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit with HI/LO registers for the MIPS core. It sits beside the single-cycle ALU in the execute stage and services the R-type funcs the ALU does not handle: MULT, MULTU, DIV, DIVU, MTHI and MTLO. MFHI and MFLO read the `hi`/`lo` outputs directly. The unit runs one operation at a time over DATA_WIDTH+1 cycles and raises `busy` so the hazard logic can stall the pipeline.

## Interface
- DATA_WIDTH, default 32: operand, HI and LO width.
- clk  in  1  clock; everything is updated on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request qualifier; sampled only when the unit is idle.
- func  in  6  R-type func field: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011. Any other value is a no-op.
- op_a  in  DATA_WIDTH  rs value (multiplicand / dividend / MTHI or MTLO source).
- op_b  in  DATA_WIDTH  rt value (multiplier / divisor).
- busy  out  1  high while an operation is in flight (state != IDLE).
- done  out  1  one-cycle pulse after HI/LO are written by MULT, MULTU, DIV or DIVU.
- hi  out  DATA_WIDTH  HI register.
- lo  out  DATA_WIDTH  LO register.

## Operation
- States: IDLE, MUL, DIV, FIX. Reset puts the unit in IDLE with hi=0, lo=0, done=0, busy=0 and the iteration counter at 0.
- IDLE with start=1:
  - MULT/MULTU: latch operands; go to MUL.
  - DIV/DIVU: latch operands; go to DIV.
  - MTHI: hi<=op_a. MTLO: lo<=op_a. Stay in IDLE; no busy, no done.
  - Any other func: ignored.
- Signed ops (MULT, DIV):
  - Latch |op_a| and |op_b|, plus the result signs.
  - Product sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
  - |-2^(W-1)| is held as unsigned 2^(W-1).
- Unsigned ops use the operands as-is and both signs are 0.
- MUL: shift-add over a 2W-bit accumulator, one multiplier bit per cycle, DATA_WIDTH iterations.
- DIV: restoring divide, one quotient bit per cycle, DATA_WIDTH iterations.
- After the last iteration: MUL or DIV -> FIX.
- FIX: apply two's-complement negation where the sign bit is set, write hi/lo, set done, go to IDLE.
  - Multiply: hi = upper W bits of the product, lo = lower W bits.
  - Divide: lo = quotient, hi = remainder.
- Divide by zero (op_b=0, signed or unsigned): normal latency; result lo = all ones, hi = op_a as originally presented (sign fix-up bypassed).
- Signed overflow -2^(W-1) / -1: lo = 0x80000000, hi = 0 for W=32. This falls out of the abs/negate path; no special case.
- hi/lo keep their previous values during MUL/DIV. Intermediates live in internal registers; hi/lo are written only in FIX or by MTHI/MTLO.
- start while busy is ignored, including MTHI/MTLO. The pipeline must hold the instruction using `busy`.

## Timing
- Edge E0: start accepted in IDLE; busy=1 from E0.
- Edges E1..E_W: one iteration each (W = DATA_WIDTH).
- Edge E_(W+1): FIX writes hi/lo; busy=0 and done=1 for exactly one cycle after that edge.
- Latency from start edge to hi/lo valid is W+1 edges (33 for W=32). busy is high for 33 cycles.
- A new start can be accepted in the same cycle done is high (state is IDLE), giving back-to-back operations.
- MTHI/MTLO: the value is visible on hi/lo the cycle after the accepting edge.
- reset during any state: next edge gives IDLE, hi=lo=0, done=0. The in-flight result is discarded.
- done is never asserted for MTHI, MTLO, no-op funcs or ignored starts.

## Test plan
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done 33 edges after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then, back-to-back in the done cycle, DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x1234 then MTLO 0x5678 in consecutive idle cycles -> hi=0x1234, lo=0x5678, busy and done stay 0. MTLO 0xDEAD issued while busy -> lo unchanged.
- Start MULTU 7 x 9, then assert reset at iteration 10 -> next cycle hi=lo=0, busy=0, done never pulses. A fresh MULTU 7 x 9 -> lo=63, hi=0.
- Start with a non-muldiv func (e.g. 100000) -> no state change, busy=0, hi/lo unchanged.
